// File: rtl/tetris_pkg.sv
// tetris_pkg: keycodes, action encoding and key-repeat FSM states shared by the input path
package tetris_pkg;
    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    typedef enum logic [2:0] {
        ACT_NONE   = 3'd0,
        ACT_LEFT   = 3'd1,
        ACT_RIGHT  = 3'd2,
        ACT_ROTATE = 3'd3,
        ACT_SOFT   = 3'd4,
        ACT_HARD   = 3'd5
    } action_t;

    typedef enum logic [1:0] {IDLE, DAS, REPEAT, LOCKED} state_t;

    function automatic action_t map_key(input logic [7:0] kc);
        return kc == KEY_A     ? ACT_LEFT   :
               kc == KEY_D     ? ACT_RIGHT  :
               kc == KEY_W     ? ACT_ROTATE :
               kc == KEY_S     ? ACT_SOFT   :
               kc == KEY_SPACE ? ACT_HARD   : ACT_NONE;
    endfunction
endpackage

// File: rtl/frame_tick_sync.sv
// frame_tick_sync: two-flop synchroniser for the vsync strobe plus rising-edge pulse
module frame_tick_sync (
    input  logic clk,
    input  logic reset,
    input  logic frame_clk,
    output logic frame_tick
);
    logic [2:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[1:0], frame_clk};
    end

    assign frame_tick = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/key_repeat.sv
// key_repeat: maps HID keycodes to game actions with DAS/ARR auto-repeat timed in frames
module key_repeat
    import tetris_pkg::*;
#(
    parameter int DAS_FRAMES  = 10,
    parameter int ARR_FRAMES  = 3,
    parameter int DROP_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic       move_left,
    output logic       move_right,
    output logic       rotate,
    output logic       soft_drop,
    output logic       hard_drop,
    output logic [2:0] active_key
);
    localparam logic [5:0] DAS_CNT  = 6'(DAS_FRAMES);
    localparam logic [5:0] ARR_CNT  = 6'(ARR_FRAMES);
    localparam logic [5:0] DROP_CNT = 6'(DROP_FRAMES);

    logic [7:0] kc_q, kc_prev;
    logic [5:0] cnt_q, cnt_d;
    state_t     state_q, state_d;
    action_t    act_q, act_d, pulse_q, pulse_d, new_act;
    logic       frame_tick, changed, lateral;

    frame_tick_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .frame_clk  (frame_clk),
        .frame_tick (frame_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kc_q    <= KEY_NONE;
            kc_prev <= KEY_NONE;
            state_q <= IDLE;
            cnt_q   <= '0;
            act_q   <= ACT_NONE;
            pulse_q <= ACT_NONE;
        end else begin
            kc_q    <= keycode;
            kc_prev <= kc_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            pulse_q <= pulse_d;
        end
    end

    assign new_act = map_key(kc_q);
    assign changed = kc_q != kc_prev;
    assign lateral = new_act == ACT_LEFT || new_act == ACT_RIGHT;

    // A key change takes priority over a coincident frame tick, which is dropped
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        pulse_d = ACT_NONE;
        if (new_act == ACT_NONE) begin
            state_d = IDLE;
            cnt_d   = '0;
            act_d   = ACT_NONE;
        end else if (changed) begin
            pulse_d = new_act;
            act_d   = new_act;
            state_d = lateral ? DAS : new_act == ACT_SOFT ? REPEAT : LOCKED;
            cnt_d   = lateral ? DAS_CNT : new_act == ACT_SOFT ? DROP_CNT : 6'd0;
        end else if (frame_tick && (state_q == DAS || state_q == REPEAT)) begin
            if (cnt_q == 6'd1) begin
                pulse_d = act_q;
                state_d = REPEAT;
                cnt_d   = act_q == ACT_SOFT ? DROP_CNT : ARR_CNT;
            end else if (cnt_q > 6'd1) begin
                cnt_d = cnt_q - 6'd1;
            end
        end
    end

    assign move_left  = pulse_q == ACT_LEFT;
    assign move_right = pulse_q == ACT_RIGHT;
    assign rotate     = pulse_q == ACT_ROTATE;
    assign soft_drop  = pulse_q == ACT_SOFT;
    assign hard_drop  = pulse_q == ACT_HARD;
    assign active_key = act_q;
endmodule

// File: tb/tb_key_repeat.sv
// tb_key_repeat: scenario tasks against a frame-count model of key auto-repeat
module tb_key_repeat;
    localparam int DAS_F = 10, ARR_F = 3, DROP_F = 2;

    logic       clk = 0, reset = 1, frame_clk = 0;
    logic [7:0] keycode = 8'h00;
    logic       move_left, move_right, rotate, soft_drop, hard_drop;
    logic [2:0] active_key;
    int         checks = 0, failures = 0, frame_num = 0;
    int         tot [5];
    int         left_q[$], soft_q[$];

    key_repeat #(.DAS_FRAMES(DAS_F), .ARR_FRAMES(ARR_F), .DROP_FRAMES(DROP_F)) dut (
        .clk(clk), .reset(reset), .frame_clk(frame_clk), .keycode(keycode),
        .move_left(move_left), .move_right(move_right), .rotate(rotate),
        .soft_drop(soft_drop), .hard_drop(hard_drop), .active_key(active_key)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 5; i++) tot[i] = 0;

    always @(negedge clk) begin
        if ($countones({hard_drop, soft_drop, rotate, move_right, move_left}) > 1) begin
            failures++;
            $display("FAIL onehot pulses=%b required at most one high", {hard_drop, soft_drop, rotate, move_right, move_left});
        end
        if (move_left)  begin tot[0]++; left_q.push_back(frame_num); end
        if (move_right) tot[1]++;
        if (rotate)     tot[2]++;
        if (soft_drop)  begin tot[3]++; soft_q.push_back(frame_num); end
        if (hard_drop)  tot[4]++;
    end

    function automatic int key_act(input logic [7:0] k);
        case (k)
            8'h04: return 0;
            8'h07: return 1;
            8'h1A: return 2;
            8'h16: return 3;
            8'h2C: return 4;
            default: return -1;
        endcase
    endfunction

    // Whether an action fires on frame f of an uninterrupted hold (frame 0 = press)
    function automatic bit fires(input int a, input int f);
        case (a)
            0, 1: return f == 0 || f == DAS_F || (f > DAS_F && (f - DAS_F) % ARR_F == 0);
            3: return f % DROP_F == 0;
            2, 4: return f == 0;
            default: return 0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_frame();
        step();
        frame_clk = 1;
        frame_num++;
        repeat (4) step();
        frame_clk = 0;
        repeat (4) step();
    endtask

    task automatic release_key();
        step();
        keycode = 8'h00;
        repeat (4) step();
    endtask

    task automatic hold(input logic [7:0] k, input int n);
        frame_num = 0;
        step();
        keycode = k;
        repeat (3) step();
        repeat (n) do_frame();
        release_key();
    endtask

    task automatic test_reset();
        keycode = 8'h07;
        repeat (3) step();
        checks++;
        if ({hard_drop, soft_drop, rotate, move_right, move_left, active_key} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=00", {hard_drop, soft_drop, rotate, move_right, move_left, active_key});
        end
        keycode = 8'h00;
        step();
        reset = 0;
        repeat (3) step();
        checks++;
        if (active_key !== 3'd0) begin
            failures++;
            $display("FAIL reset_idle active_key=%0d want=0", active_key);
        end
    endtask

    task automatic test_tap();
        int b1;
        b1 = tot[1];
        frame_num = 0;
        step();
        keycode = 8'h07;
        step();
        checks++;
        if (move_right !== 1'b0) begin failures++; $display("FAIL tap_early move_right=%b want=0", move_right); end
        step();
        checks++;
        if (move_right !== 1'b1 || active_key !== 3'd2) begin
            failures++;
            $display("FAIL tap_pulse move_right=%b active_key=%0d want=1/2", move_right, active_key);
        end
        step();
        checks++;
        if (move_right !== 1'b0) begin failures++; $display("FAIL tap_width move_right=%b want=0", move_right); end
        repeat (3) do_frame();
        release_key();
        checks++;
        if (tot[1] - b1 != 1 || active_key !== 3'd0) begin
            failures++;
            $display("FAIL tap_total pulses=%0d active_key=%0d want=1/0", tot[1] - b1, active_key);
        end
    endtask

    task automatic test_hold_left();
        int lb, exp_q[$];
        lb = left_q.size();
        for (int f = 0; f <= 20; f++) if (fires(0, f)) exp_q.push_back(f);
        hold(8'h04, 20);
        checks++;
        if (left_q.size() - lb != exp_q.size()) begin
            failures++;
            $display("FAIL hold_left_count got=%0d want=%0d", left_q.size() - lb, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (left_q[lb + i] != exp_q[i]) begin
                    failures++;
                    $display("FAIL hold_left_frame idx=%0d got=%0d want=%0d", i, left_q[lb + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_locked();
        int br, bh;
        br = tot[2];
        bh = tot[4];
        hold(8'h1A, 30);
        checks++;
        if (tot[2] - br != 1) begin failures++; $display("FAIL locked_rotate got=%0d want=1", tot[2] - br); end
        hold(8'h2C, 30);
        checks++;
        if (tot[4] - bh != 1) begin failures++; $display("FAIL locked_hard got=%0d want=1", tot[4] - bh); end
    endtask

    task automatic test_soft_switch();
        int sb, lb, sc;
        int exp_s[$];
        sb = soft_q.size();
        for (int f = 0; f <= 6; f++) if (fires(3, f)) exp_s.push_back(f);
        frame_num = 0;
        step();
        keycode = 8'h16;
        repeat (3) step();
        repeat (6) do_frame();
        checks++;
        if (soft_q.size() - sb != exp_s.size()) begin
            failures++;
            $display("FAIL soft_count got=%0d want=%0d", soft_q.size() - sb, exp_s.size());
        end else begin
            for (int i = 0; i < exp_s.size(); i++) begin
                checks++;
                if (soft_q[sb + i] != exp_s[i]) begin
                    failures++;
                    $display("FAIL soft_frame idx=%0d got=%0d want=%0d", i, soft_q[sb + i], exp_s[i]);
                end
            end
        end
        sc = soft_q.size();
        lb = left_q.size();
        frame_num = 0;
        step();
        keycode = 8'h04;
        step();
        checks++;
        if (move_left !== 1'b0) begin failures++; $display("FAIL switch_early move_left=%b want=0", move_left); end
        step();
        checks++;
        if (move_left !== 1'b1 || active_key !== 3'd1) begin
            failures++;
            $display("FAIL switch_pulse move_left=%b active_key=%0d want=1/1", move_left, active_key);
        end
        repeat (DAS_F) do_frame();
        release_key();
        checks++;
        if (left_q.size() - lb != 2 || left_q[lb] != 0 || left_q[lb + 1] != DAS_F || soft_q.size() != sc) begin
            failures++;
            $display("FAIL switch_das left_pulses=%0d soft_extra=%0d want=2/0", left_q.size() - lb, soft_q.size() - sc);
        end
    endtask

    task automatic test_coincident();
        int br, lb, b[5];
        frame_num = 0;
        step();
        keycode = 8'h07;
        repeat (3) step();
        repeat (DAS_F - 1) do_frame();
        br = tot[1];
        lb = left_q.size();
        frame_num = 0;
        step();
        frame_clk = 1;
        step();
        keycode = 8'h04;
        repeat (3) step();
        frame_clk = 0;
        repeat (4) step();
        repeat (DAS_F) do_frame();
        release_key();
        checks++;
        if (tot[1] - br != 0) begin failures++; $display("FAIL coincide_right got=%0d want=0", tot[1] - br); end
        checks++;
        if (left_q.size() - lb != 2 || left_q[lb] != 0 || left_q[lb + 1] != DAS_F) begin
            failures++;
            $display("FAIL coincide_das left_pulses=%0d want=2 at frames 0,%0d", left_q.size() - lb, DAS_F);
        end
        for (int i = 0; i < 5; i++) b[i] = tot[i];
        step();
        keycode = 8'h29;
        repeat (3) step();
        checks++;
        if (active_key !== 3'd0) begin failures++; $display("FAIL unmapped_active got=%0d want=0", active_key); end
        repeat (3) do_frame();
        release_key();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (tot[i] != b[i]) begin failures++; $display("FAIL unmapped_pulse act=%0d got=%0d want=0", i, tot[i] - b[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int bl;
        frame_num = 0;
        step();
        keycode = 8'h04;
        repeat (3) step();
        repeat (DAS_F + 2) do_frame();
        checks++;
        if (active_key !== 3'd1) begin failures++; $display("FAIL mid_active got=%0d want=1", active_key); end
        @(posedge clk);
        #3 reset = 1;
        #1;
        checks++;
        if ({hard_drop, soft_drop, rotate, move_right, move_left, active_key} !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset_async got=%h want=00", {hard_drop, soft_drop, rotate, move_right, move_left, active_key});
        end
        step();
        step();
        reset = 0;
        bl = tot[0];
        step();
        checks++;
        if (move_left !== 1'b0) begin failures++; $display("FAIL mid_release_early move_left=%b want=0", move_left); end
        step();
        checks++;
        if (move_left !== 1'b1) begin failures++; $display("FAIL mid_release_pulse move_left=%b want=1", move_left); end
        release_key();
        checks++;
        if (tot[0] - bl != 1) begin failures++; $display("FAIL mid_release_total got=%0d want=1", tot[0] - bl); end
    endtask

    task automatic test_random();
        logic [7:0] keys [5] = '{8'h04, 8'h07, 8'h1A, 8'h16, 8'h2C};
        logic [7:0] k;
        int n, a, want, b[5];
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 5) == 5) begin
                do k = 8'($urandom_range(0, 255)); while (key_act(k) >= 0);
            end else begin
                k = keys[$urandom_range(0, 4)];
            end
            n = $urandom_range(0, 25);
            a = key_act(k);
            for (int i = 0; i < 5; i++) b[i] = tot[i];
            hold(k, n);
            for (int i = 0; i < 5; i++) begin
                want = 0;
                if (i == a) for (int f = 0; f <= n; f++) want += int'(fires(a, f));
                checks++;
                if (tot[i] - b[i] != want) begin
                    failures++;
                    $display("FAIL random key=%h frames=%0d act=%0d got=%0d want=%0d", k, n, i, tot[i] - b[i], want);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_tap();
        test_hold_left();
        test_locked();
        test_soft_switch();
        test_coincident();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/key_repeat.md
KEY_REPEAT -- requirements
Module: key_repeat

Interface
REQ-001 Parameter DAS_FRAMES, default 10, frames a move key is held before auto-repeat starts (legal 1..63).
REQ-002 Parameter ARR_FRAMES, default 3, frames between auto-repeat pulses (legal 1..63).
REQ-003 Parameter DROP_FRAMES, default 2, frames between soft-drop repeat pulses (legal 1..63).
REQ-004 clk  in  1  system clock (50 MHz); the block has one clock; reset is asynchronous and active-high.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 frame_clk  in  1  frame strobe (inverted VGA vsync), asynchronous to clk.
REQ-007 keycode  in  8  raw USB HID keycode from the SoC PIO; 0x00 = no key.
REQ-008 move_left, move_right, rotate, soft_drop, hard_drop  out  1 each  single-clk action pulses to the game logic.
REQ-009 active_key  out  3  encoded action currently held (0 none, 1 left, 2 right, 3 rotate, 4 soft, 5 hard).

Function
REQ-010 Keycode map: 0x04 (A) left, 0x07 (D) right, 0x1A (W) rotate, 0x16 (S) soft drop, 0x2C (Space) hard drop; every other code is treated as 0x00.
REQ-011 keycode is registered once (kc_q); a key change is kc_q differing from its previous registered value.
REQ-012 A change to a mapped key drives that action's pulse high exactly 2 clk after keycode changes, for exactly 1 clk.
REQ-013 frame_clk is 2-flop synchronised; frame_tick is a 1-clk pulse on each synchronised rising edge.
REQ-014 FSM states: IDLE, DAS, REPEAT, LOCKED.
REQ-015 IDLE: mapped key change -> left/right go to DAS, with counter = DAS_FRAMES; soft drop goes to REPEAT, with counter = DROP_FRAMES; rotate and hard drop go to LOCKED.
REQ-016 DAS: each frame_tick decrements the counter; on a tick with counter == 1, pulse the action, load ARR_FRAMES, and go to REPEAT.
REQ-017 REPEAT: each frame_tick decrements; on a tick with counter == 1, pulse the action and reload ARR_FRAMES (left/right) or DROP_FRAMES (soft).
REQ-018 LOCKED: no further pulses until the key changes.
REQ-019 Any state: kc_q becoming unmapped or 0x00 -> IDLE, counter cleared, no pulse.
REQ-020 Any state: change directly to a different mapped key -> immediate pulse of the new action per REQ-012, then per REQ-015.
REQ-021 Key change and frame_tick in the same cycle: the key change wins and the tick is discarded.
REQ-022 Counter is 6 bit, never decrements below 1, and never wraps.
REQ-023 At most one action pulse is high in any cycle.
REQ-024 active_key reflects the FSM's current action, and is 0 in IDLE.

Reset
REQ-025 On reset assertion (asynchronous), state = IDLE, counter = 0, kc_q = 0x00, sync flops = 0, all pulses = 0, active_key = 0.
REQ-026 Reset mid-hold: after release, a still-held key counts as a new change and produces a pulse 2 clk later.

Structure
REQ-027 Shared package tetris_pkg holds the keycode constants, the action encoding used for active_key, and the FSM state enum.
REQ-028 One sub-module, frame_tick_sync, implements the synchroniser and rising-edge detector for REQ-013.
REQ-029 The remaining logic (mapping, FSM, counter, output registers) stays in key_repeat.

Verification
REQ-030 Tap D (0x07) for 3 frames then 0x00 -> exactly one move_right pulse, 2 clk after the change; active_key returns to 0.
REQ-031 Hold A for 20 frames with defaults -> pulses at frame 0, frame 10, then every 3 frames (13, 16, 19): 5 pulses total.
REQ-032 Hold W (0x1A) or Space (0x2C) for 30 frames -> exactly one rotate or hard_drop pulse.
REQ-033 Hold S for 6 frames -> soft_drop pulses at frames 0, 2, 4, 6; then switch directly to A -> move_left 2 clk later and DAS restarts.
REQ-034 Key change coincident with frame_tick -> no extra pulse, counter = DAS_FRAMES; keycode 0x29 -> no pulses, active_key = 0.
REQ-035 Assert reset in REPEAT while A is held -> outputs 0 immediately; after release, a move_left pulse 2 clk later.
